// File: rtl/rv32_inst_encoder.sv
// RV32I field-to-word encoder: two-stage valid/ready pipeline (classify, then pack).
// Optional immediate range checking is enabled by defining RV32_ENCODER_IMM_CHECK_EN.
module rv32_inst_encoder #(
  parameter int unsigned CNT_W        = 16,
  parameter logic [31:0] ILLEGAL_INST = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             out_error,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] error_count
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  fmt_e        cls_fmt;
  logic        cls_err;
  logic        s2_can_take;
  logic [31:0] pack;

  logic        s1_valid;
  fmt_e        s1_fmt;
  logic        s1_err;
  logic [6:0]  s1_op;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_f3;
  logic [6:0]  s1_f7;
  logic [31:0] s1_imm;

  assign s2_can_take = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_take;

  always_comb begin
    cls_fmt = FmtR;
    cls_err = 1'b0;
    case (in_opcode)
      OpReg:                              cls_fmt = FmtR;
      OpImm:                              cls_fmt = (in_funct3[1:0] == 2'b01) ? FmtSh : FmtI;
      OpLoad, OpJalr, OpMisc, OpSystem:   cls_fmt = FmtI;
      OpStore:                            cls_fmt = FmtS;
      OpBranch:                           cls_fmt = FmtB;
      OpLui, OpAuipc:                     cls_fmt = FmtU;
      OpJal:                              cls_fmt = FmtJ;
      default:                            cls_err = 1'b1;
    endcase
`ifdef RV32_ENCODER_IMM_CHECK_EN
    // Upper bits must be a pure sign extension of the field's top bit.
    if (!cls_err) begin
      case (cls_fmt)
        FmtI, FmtS: cls_err = !(&in_imm[31:11] || ~|in_imm[31:11]);
        FmtB:       cls_err = !(&in_imm[31:12] || ~|in_imm[31:12]) || in_imm[0];
        FmtJ:       cls_err = !(&in_imm[31:20] || ~|in_imm[31:20]) || in_imm[0];
        FmtU:       cls_err = |in_imm[11:0];
        FmtSh:      cls_err = |in_imm[31:5];
        default:    cls_err = 1'b0;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_fmt   <= FmtR;
      s1_err   <= 1'b0;
      s1_op    <= '0;
      s1_rd    <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
      s1_f3    <= '0;
      s1_f7    <= '0;
      s1_imm   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt <= cls_fmt;
        s1_err <= cls_err;
        s1_op  <= in_opcode;
        s1_rd  <= in_rd;
        s1_rs1 <= in_rs1;
        s1_rs2 <= in_rs2;
        s1_f3  <= in_funct3;
        s1_f7  <= in_funct7;
        s1_imm <= in_imm;
      end
    end
  end

  always_comb begin
    pack = ILLEGAL_INST;
    if (!s1_err) begin
      case (s1_fmt)
        FmtR:  pack = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
        FmtI:  pack = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
        FmtSh: pack = {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op};
        FmtS:  pack = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
        FmtB:  pack = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:1],
                       s1_imm[11], s1_op};
        FmtU:  pack = {s1_imm[31:12], s1_rd, s1_op};
        FmtJ:  pack = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
        default: pack = ILLEGAL_INST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_error <= 1'b0;
    end else if (s2_can_take) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst  <= pack;
        out_error <= s1_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_count  <= '0;
      error_count <= '0;
    end else if (out_valid && out_ready) begin
      if (!(&inst_count)) inst_count <= inst_count + CNT_W'(1);
      if (out_error && !(&error_count)) error_count <= error_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Directed self-checking bench for rv32_inst_encoder (narrow counters to reach saturation).
module tb_rv32_inst_encoder;

  localparam int unsigned CW  = 4;
  localparam logic [31:0] ILL = 32'h0BAD_0BAD;
  localparam int          SAT = 15;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [31:0]   in_imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic          out_error;
  logic [CW-1:0] inst_count;
  logic [CW-1:0] error_count;

  int n_tests;
  int n_fail;
  int exp_inst;
  int exp_err;

  rv32_inst_encoder #(
    .CNT_W       (CW),
    .ILLEGAL_INST(ILL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_error  (out_error),
    .inst_count (inst_count),
    .error_count(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_beat(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [31:0] imm);
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  // Sends one beat with out_ready=1 and captures the result; lat=-1 on timeout.
  task automatic run_one(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm, output logic [31:0] inst, output logic err,
                         output int lat);
    @(negedge clk);
    set_beat(op, rd, rs1, rs2, f3, f7, imm);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat  = -1;
    inst = 'x;
    err  = 1'bx;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        inst = out_inst;
        err  = out_error;
        lat  = c;
        break;
      end
    end
    if (lat != -1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_beat(7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #22;
    n_tests++;
    if (out_valid !== 1'b0 || out_inst !== 32'd0 || out_error !== 1'b0 ||
        inst_count !== '0 || error_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b inst=%h err=%b ic=%0d ec=%0d, required 0,0,0,0,0",
               out_valid, out_inst, out_error, inst_count, error_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_addi_latency();
    logic [31:0] inst;
    logic        err;
    int          lat;
    // rs2 and funct7 are don't-cares for I-type.
    run_one(7'b0010011, 5'd1, 5'd0, 5'd7, 3'd0, 7'h7F, 32'd5, inst, err, lat);
    exp_inst++;
    n_tests++;
    if (lat !== 2 || inst !== 32'h0050_0093 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_latency: lat=%0d inst=%h err=%b, required 2 00500093 0", lat, inst, err);
    end
  endtask

  task automatic test_formats();
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111,
                             7'b0010011, 7'b0010011, 7'b0000011, 7'b0010111};
    logic [4:0]  rds [9] = '{5'd3, 5'd31, 5'd0, 5'd1, 5'd5, 5'd1, 5'd1, 5'd4, 5'd2};
    logic [4:0]  r1s [9] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1, 5'd2, 5'd0};
    logic [4:0]  r2s [9] = '{5'd2, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    logic [2:0]  f3s [9] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd1, 3'd5, 3'd2, 3'd0};
    logic [6:0]  f7s [9] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
    logic [31:0] imms[9] = '{32'd0, 32'd8, 32'hFFFF_FFFC, 32'h800, 32'h1234_5000, 32'd3,
                             32'd3, 32'hFFFF_FFFF, 32'h0000_1000};
    logic [31:0] exps[9] = '{32'h0020_81B3, 32'h0020_A423, 32'hFE20_8EE3, 32'h0010_00EF,
                             32'h1234_52B7, 32'h0030_9093, 32'h4030_D093, 32'hFFF1_2203,
                             32'h0000_1117};
    logic [31:0] inst;
    logic        err;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_one(ops[i], rds[i], r1s[i], r2s[i], f3s[i], f7s[i], imms[i], inst, err, lat);
      exp_inst++;
      n_tests++;
      if (lat !== 2 || inst !== exps[i] || err !== 1'b0) begin
        n_fail++;
        $display("FAIL format_%0d: lat=%0d inst=%h err=%b, required 2 %h 0",
                 i, lat, inst, err, exps[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] inst;
    logic        err;
    int          lat;
    run_one(7'b1111111, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, inst, err, lat);
    exp_inst++;
    exp_err++;
    n_tests++;
    if (lat !== 2 || inst !== ILL || err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_opcode: lat=%0d inst=%h err=%b, required 2 %h 1", lat, inst, err, ILL);
    end
  endtask

  task automatic test_imm_range();
    logic [31:0] inst;
    logic        err;
    int          lat;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_e;
`ifdef RV32_ENCODER_IMM_CHECK_EN
    exp_a = ILL;
    exp_b = ILL;
    exp_e = 1'b1;
`else
    exp_a = 32'h8000_0093;
    exp_b = 32'h0020_8163;
    exp_e = 1'b0;
`endif
    run_one(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, inst, err, lat);
    exp_inst++;
    if (exp_e) exp_err++;
    n_tests++;
    if (lat !== 2 || inst !== exp_a || err !== exp_e) begin
      n_fail++;
      $display("FAIL imm_addi_2048: lat=%0d inst=%h err=%b, required 2 %h %b",
               lat, inst, err, exp_a, exp_e);
    end
    // Odd branch offset.
    run_one(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, inst, err, lat);
    exp_inst++;
    if (exp_e) exp_err++;
    n_tests++;
    if (lat !== 2 || inst !== exp_b || err !== exp_e) begin
      n_fail++;
      $display("FAIL imm_branch_odd: lat=%0d inst=%h err=%b, required 2 %h %b",
               lat, inst, err, exp_b, exp_e);
    end
  endtask

  task automatic test_counters();
    int ei;
    int ee;
    @(negedge clk);
    ei = (exp_inst > SAT) ? SAT : exp_inst;
    ee = (exp_err > SAT) ? SAT : exp_err;
    n_tests++;
    if (int'(inst_count) !== ei || int'(error_count) !== ee) begin
      n_fail++;
      $display("FAIL counters: ic=%0d ec=%0d, required %0d %0d", inst_count, error_count, ei, ee);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] imms[3] = '{32'd5, 32'd10, 32'd15};
    logic [31:0] exps[3] = '{32'h0050_0093, 32'h00A0_0093, 32'h00F0_0093};
    logic [31:0] got[3];
    int          idx;
    int          ngot;
    logic        fire_in;
    logic        fire_out;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idx  = 0;
    ngot = 0;
    set_beat(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imms[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      fire_in = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire_in) begin
        idx++;
        if (idx < 3) set_beat(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imms[idx]);
        else in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_tests++;
    if (idx !== 2 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: accepted=%0d in_ready=%b, required 2 0", idx, in_ready);
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_inst !== exps[0] || out_error !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b inst=%h err=%b, required 1 %h 0",
               out_valid, out_inst, out_error, exps[0]);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int c = 0; c < 20 && ngot < 3; c++) begin
      @(negedge clk);
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        got[ngot] = out_inst;
        ngot++;
      end
      @(posedge clk);
      #1;
      if (fire_in) begin
        idx++;
        if (idx < 3) set_beat(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, imms[idx]);
        else in_valid = 1'b0;
      end
    end
    exp_inst += 3;
    n_tests++;
    if (ngot !== 3) begin
      n_fail++;
      $display("FAIL bp_drain_count: got %0d beats, required 3", ngot);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (got[i] !== exps[i]) begin
          n_fail++;
          $display("FAIL bp_order_%0d: got %h, required %h", i, got[i], exps[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    set_beat(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    @(posedge clk);
    #1 set_beat(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_inst = 0;
    exp_err  = 0;
    n_tests++;
    if (out_valid !== 1'b0 || inst_count !== '0 || error_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b ic=%0d ec=%0d, required 0 0 0",
               out_valid, inst_count, error_count);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_tests++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_drop: %0d beats emitted after release, required 0", seen);
    end
  endtask

  task automatic test_back_to_back_saturate();
    int stalls;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    set_beat(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1;
    stalls   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!in_ready) stalls++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (stalls !== 0) begin
      n_fail++;
      $display("FAIL throughput: %0d stall cycles, required 0", stalls);
    end
    n_tests++;
    if (int'(inst_count) !== SAT || int'(error_count) !== SAT) begin
      n_fail++;
      $display("FAIL saturate: ic=%0d ec=%0d, required %0d %0d",
               inst_count, error_count, SAT, SAT);
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_inst = 0;
    exp_err  = 0;
    test_reset();
    test_addi_latency();
    test_formats();
    test_illegal();
    test_imm_range();
    test_counters();
    test_backpressure();
    test_counters();
    test_reset_midflight();
    test_back_to_back_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
